oai_test_sequencer: RTL and testbench
=====================================

Name: oai_test_sequencer

Overview:
- Synthesizable, clocked controller that sequences an exhaustive functional test of the 4-input OAI22 basic cell, y = ~((a|b)&(c|d)).
- Drives the cell inputs through all 16 combinations in binary order, with {a,b,c,d} = 0000..1111 and a as MSB.
- Holds each vector for a programmable number of cycles and samples the cell output at the end of each window.
- Compares each sample against a golden model and reports error count, first failing vector and pass/fail.
- Sits beside the cell under test in the basic_cells bench and in the on-chip self-test wrapper.

Parameters:
- HOLD_CYCLES, 2, cycles each vector is applied (legal range 1..15).
- ERR_W, 5, width of err_count (must hold the value 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_y  in  1  output of the cell under test.
- a  out  1  cell input a (vector bit 3).
- b  out  1  cell input b (vector bit 2).
- c  out  1  cell input c (vector bit 1).
- d  out  1  cell input d (vector bit 0).
- busy  out  1  high while vectors are being applied.
- done  out  1  high (level) once a run completes, until the next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors in the last run.
- first_err_vec  out  4  {a,b,c,d} of the first mismatch; 0 if none.
- first_err_valid  out  1  high once any mismatch has been recorded in the current run.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, a=b=c=d=0, busy=0, done=0, pass=0.
  - err_count=0, first_err_vec=0, first_err_valid=0, hold_cnt=0.
- All outputs are registered. a/b/c/d are driven directly from the 4-bit vector register.
- States:
  - IDLE: vector=0. On start, go to RUN on the next edge. Clear err_count, first_err_vec and first_err_valid; hold_cnt=0.
  - RUN: busy=1.
    - Each cycle hold_cnt increments.
    - On the edge where hold_cnt==HOLD_CYCLES-1, compare dut_y with golden(vector).
    - On mismatch, err_count+=1. If first_err_valid==0, latch first_err_vec=vector and set first_err_valid.
    - On that same edge, if vector==15, go to DONE with vector=0. Otherwise vector+=1 and hold_cnt=0.
  - DONE: busy=0, done=1, vector held at 0. On start, go to RUN with counters cleared, exactly as from IDLE.
- Timing:
  - A run lasts exactly 16*HOLD_CYCLES cycles of busy=1.
  - done rises on the cycle after the last sample.
- dut_y is sampled on the last cycle of each window. The cell's settling time must be under HOLD_CYCLES-1 cycles plus one clock period.
- start is ignored while in RUN; no restart and no abort.
- With HOLD_CYCLES=1 the vector changes every cycle and is sampled every cycle; there are no idle gaps.
- err_count never exceeds 16, so no saturation logic is needed.
- Asserting rst mid-run returns all state to reset values immediately. The next run starts from vector 0.
- Golden model values:
  - y=1 for vectors 0,1,2,3,4,8,12.
  - y=0 for all other vectors.

Decomposition:
- Package oai_test_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - N_VEC=16 and VEC_W=4.
  - Function oai22_golden(vec), returning ~((vec[3]|vec[2])&(vec[1]|vec[0])).
- One natural sub-module, oai_hold_timer: a hold_cnt counter with clear and a terminal-count output (hold_cnt==HOLD_CYCLES-1). The top holds the FSM, vector register and checker.

Test Plan:
- Connect a behavioural OAI22 to dut_y, HOLD_CYCLES=2, pulse start -> 32 busy cycles with vectors 0..15 each held 2 cycles; then done=1, pass=1, err_count=0, first_err_valid=0.
- Tie dut_y=0 -> err_count=7, first_err_vec=0000, pass=0.
- Tie dut_y=1 -> err_count=9, first_err_vec=0101.
- Drive dut_y as the inverted golden output -> err_count=16, first_err_vec=0000.
- Assert rst at vector 7 -> all outputs return to 0 immediately. A new start gives a full 32-cycle run and err_count is counted from 0.
- Pulse start while busy -> no effect.
- Pulse start in DONE -> a new run starts and err_count clears.
- With HOLD_CYCLES=1 -> 16 busy cycles and a new vector every cycle.

Source files
------------

// File: rtl/oai_test_pkg.sv
// Shared types and golden model for the OAI22 exhaustive test sequencer.
package oai_test_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int N_VEC = 16;
   localparam int VEC_W = 4;

   function automatic logic oai22_golden(input logic [VEC_W-1:0] vec);
      return ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
   endfunction

endpackage

// File: rtl/oai_hold_timer.sv
// Counts cycles within one vector window; tc_o flags the last cycle of the window.
module oai_hold_timer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [3:0] TC_VAL = 4'(HOLD_CYCLES - 1);

   logic [3:0] hold_cnt_q;
   logic [3:0] hold_cnt_d;

   assign tc_o = (hold_cnt_q == TC_VAL);

   // Wraps to 0 at terminal count so the next vector starts a fresh window.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (clr_i || (en_i && tc_o)) begin
         hold_cnt_d = '0;
      end else if (en_i) begin
         hold_cnt_d = hold_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/oai_test_sequencer.sv
// Walks all 16 OAI22 input vectors, samples the cell at the end of each hold
// window and reports error count, first failing vector and pass/fail.
module oai_test_sequencer
   import oai_test_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int ERR_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dut_y,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       first_err_vec,
   output logic             first_err_valid
);

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [VEC_W-1:0]   ferr_vec_q, ferr_vec_d;
   logic               ferr_vld_q, ferr_vld_d;
   logic               tc;
   logic               in_run;

   assign in_run = (state_q == RUN);

   oai_hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .clr_i(!in_run),
      .en_i (in_run),
      .tc_o (tc)
   );

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      ferr_vec_d = ferr_vec_q;
      ferr_vld_d = ferr_vld_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               vec_d      = '0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               err_d      = '0;
               ferr_vec_d = '0;
               ferr_vld_d = 1'b0;
            end
         end
         RUN: begin
            if (tc) begin
               if (dut_y != oai22_golden(vec_q)) begin
                  err_d = err_q + ERR_W'(1);
                  if (!ferr_vld_q) begin
                     ferr_vec_d = vec_q;
                     ferr_vld_d = 1'b1;
                  end
               end
               // pass uses err_d so the final vector's result is included.
               if (vec_q == LAST_VEC) begin
                  state_d = DONE;
                  vec_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end else begin
                  vec_d = vec_q + VEC_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         ferr_vec_q <= '0;
         ferr_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         ferr_vec_q <= ferr_vec_d;
         ferr_vld_q <= ferr_vld_d;
      end
   end

   assign a               = vec_q[3];
   assign b               = vec_q[2];
   assign c               = vec_q[1];
   assign d               = vec_q[0];
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_vec   = ferr_vec_q;
   assign first_err_valid = ferr_vld_q;

endmodule

// File: tb/tb_oai_test_sequencer.sv
// Bench for oai_test_sequencer: instance 0 uses HOLD_CYCLES=2, instance 1 uses HOLD_CYCLES=1.
module tb_oai_test_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   int         mode;
   logic [15:0] rtab;

   logic       a_w   [2];
   logic       b_w   [2];
   logic       c_w   [2];
   logic       d_w   [2];
   logic       busy_w[2];
   logic       done_w[2];
   logic       pass_w[2];
   logic [4:0] err_w [2];
   logic [3:0] fev_w [2];
   logic       fvl_w [2];
   logic       y_w   [2];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden truth taken from the listed vector set rather than the boolean form.
   function automatic logic golden_ref(input logic [3:0] v);
      return (v inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd12});
   endfunction

   // Cell response for each stimulus mode: 0 good cell, 1 tied 0, 2 tied 1, 3 inverted, 4 random table.
   function automatic logic resp_f(input int m, input logic [3:0] v, input logic [15:0] t);
      case (m)
         0:       return golden_ref(v);
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return !golden_ref(v);
         default: return t[v];
      endcase
   endfunction

   always_comb y_w[0] = resp_f(mode, {a_w[0], b_w[0], c_w[0], d_w[0]}, rtab);
   always_comb y_w[1] = resp_f(mode, {a_w[1], b_w[1], c_w[1], d_w[1]}, rtab);

   oai_test_sequencer #(.HOLD_CYCLES(2), .ERR_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .dut_y(y_w[0]),
      .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .first_err_vec(fev_w[0]), .first_err_valid(fvl_w[0])
   );

   oai_test_sequencer #(.HOLD_CYCLES(1), .ERR_W(5)) dut_h1 (
      .clk(clk), .rst(rst), .start(start), .dut_y(y_w[1]),
      .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1]), .first_err_vec(fev_w[1]), .first_err_valid(fvl_w[1])
   );

   function automatic logic [13:0] all_outs(input int k);
      return {a_w[k], b_w[k], c_w[k], d_w[k], busy_w[k], done_w[k], pass_w[k],
              err_w[k][0], fev_w[k][0], fvl_w[k], |err_w[k], |fev_w[k], 2'b00};
   endfunction

   // Starts a run on both instances, follows it cycle by cycle and checks the final report.
   task automatic run_check(input string name, input int m, input bit mid_start);
      int exp_err;
      int exp_first;
      int bad_cyc[2];
      logic [3:0] v;
      logic [3:0] exp_v;
      int hc;
      mode = m;
      exp_err = 0;
      exp_first = 0;
      for (int i = 15; i >= 0; i--) begin
         v = 4'(i);
         if (resp_f(m, v, rtab) != golden_ref(v)) begin
            exp_err++;
            exp_first = i;
         end
      end

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (err_w[k] !== 5'd0 || done_w[k] !== 1'b0 || fvl_w[k] !== 1'b0 || busy_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s clear_on_start dut%0d: err=%0d done=%b fvalid=%b busy=%b, want 0 0 0 1",
                     name, k, err_w[k], done_w[k], fvl_w[k], busy_w[k]);
         end
      end

      bad_cyc[0] = -1;
      bad_cyc[1] = -1;
      for (int i = 0; i < 36; i++) begin
         if (i > 0) @(negedge clk);
         start = (mid_start && i == 10);
         for (int k = 0; k < 2; k++) begin
            hc = (k == 0) ? 2 : 1;
            exp_v = (i < 16 * hc) ? 4'(i / hc) : 4'd0;
            if (bad_cyc[k] < 0 &&
                ({a_w[k], b_w[k], c_w[k], d_w[k]} !== exp_v ||
                 busy_w[k] !== (i < 16 * hc) || done_w[k] !== (i >= 16 * hc)))
               bad_cyc[k] = i;
         end
      end
      start = 1'b0;

      for (int k = 0; k < 2; k++) begin
         checks++;
         if (bad_cyc[k] >= 0) begin
            errors++;
            $display("FAIL %s sequence dut%0d: first wrong vector/busy/done at cycle %0d, want all cycles correct",
                     name, k, bad_cyc[k]);
         end
         checks++;
         if (err_w[k] !== 5'(exp_err)) begin
            errors++;
            $display("FAIL %s err_count dut%0d: got %0d want %0d", name, k, err_w[k], exp_err);
         end
         checks++;
         if (fev_w[k] !== 4'(exp_first) || fvl_w[k] !== (exp_err > 0)) begin
            errors++;
            $display("FAIL %s first_err dut%0d: got vec=%b valid=%b want vec=%b valid=%b",
                     name, k, fev_w[k], fvl_w[k], 4'(exp_first), (exp_err > 0));
         end
         checks++;
         if (pass_w[k] !== (exp_err == 0) || done_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s pass dut%0d: got pass=%b done=%b want pass=%b done=1",
                     name, k, pass_w[k], done_w[k], (exp_err == 0));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      mode = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (all_outs(k) !== 14'd0) begin
            errors++;
            $display("FAIL reset_values dut%0d: got %b want all zero", k, all_outs(k));
         end
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (all_outs(k) !== 14'd0) begin
            errors++;
            $display("FAIL idle_after_reset dut%0d: got %b want all zero", k, all_outs(k));
         end
      end
   endtask

   task automatic test_golden();       run_check("golden", 0, 1'b0);   endtask
   task automatic test_tie0();         run_check("tie0", 1, 1'b0);     endtask
   task automatic test_tie1();         run_check("tie1", 2, 1'b0);     endtask
   task automatic test_inverted();     run_check("inverted", 3, 1'b0); endtask
   task automatic test_start_while_busy(); run_check("start_busy", 0, 1'b1); endtask

   task automatic test_start_in_done();
      run_check("done_prep", 3, 1'b0);
      run_check("restart_from_done", 0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         rtab = 16'($urandom);
         run_check("random", 4, 1'b0);
      end
   endtask

   task automatic test_rst_mid_run();
      bit found;
      mode = 1;
      found = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if ({a_w[0], b_w[0], c_w[0], d_w[0]} == 4'd7 && busy_w[0]) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_mid_run reach_vec7: vector 7 not seen within 40 cycles, want seen");
      end
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (all_outs(k) !== 14'd0) begin
            errors++;
            $display("FAIL rst_mid_run immediate dut%0d: got %b want all zero", k, all_outs(k));
         end
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      run_check("after_rst", 1, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rtab = 16'h0;
      test_reset();
      test_golden();
      test_tie0();
      test_tie1();
      test_inverted();
      test_start_while_busy();
      test_start_in_done();
      test_random();
      test_rst_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
